// File: rtl/game_pkg.sv
// Shared definitions for the whack-a-mole judge.
// Contents:
//   state_t            round-judge state encoding (2 bits)
//   BCD_W              width of one BCD score digit
//   DEFAULT_NUM_HOLES  default number of holes/buttons
//   SCORE_MAX          value at which the two-digit scores stop counting
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_ROUND = 2'd1,
        ST_ARMED      = 2'd2,
        ST_RESOLVED   = 2'd3
    } state_t;

    localparam int BCD_W             = 4;
    localparam int DEFAULT_NUM_HOLES = 16;
    localparam int SCORE_MAX         = 99;

endpackage

// File: rtl/bcd_counter_sat.sv
// Two-digit BCD counter that saturates at SCORE_MAX.
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset, clears both digits
//   clr        synchronous clear (wins over inc)
//   inc        count up by one; ignored once the counter reads SCORE_MAX
//   ones, tens BCD digits
module bcd_counter_sat
    import game_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [BCD_W-1:0] ones,
    output logic [BCD_W-1:0] tens
);

    localparam logic [BCD_W-1:0] MAX_ONES = BCD_W'(SCORE_MAX % 10);
    localparam logic [BCD_W-1:0] MAX_TENS = BCD_W'(SCORE_MAX / 10);
    localparam logic [BCD_W-1:0] NINE     = BCD_W'(9);

    logic [BCD_W-1:0] ones_reg;
    logic [BCD_W-1:0] tens_reg;
    logic             at_max;

    assign at_max = (ones_reg == MAX_ONES) && (tens_reg == MAX_TENS);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ones_reg <= '0;
            tens_reg <= '0;
        end else if (clr) begin
            ones_reg <= '0;
            tens_reg <= '0;
        end else if (inc && !at_max) begin
            if (ones_reg == NINE) begin
                ones_reg <= '0;
                tens_reg <= tens_reg + BCD_W'(1);
            end else begin
                ones_reg <= ones_reg + BCD_W'(1);
            end
        end
    end

    assign ones = ones_reg;
    assign tens = tens_reg;

endmodule

// File: rtl/hit_judge.sv
// Round judge and score keeper for the whack-a-mole game.
// Ports:
//   clk                    system clock
//   rst                    asynchronous active-low reset
//   inGame                 asynchronous game-enable level
//   round_start, position  new-round pulse and mole hole index (clk domain)
//   btn                    asynchronous active-high hole buttons
//   mole_pos, mole_active  latched mole position / mole awaiting a press
//   hit_pulse, miss_pulse  one-cycle pulse per counted hit / miss
//   hit_*, miss_*          BCD scores (ones/tens)
module hit_judge
    import game_pkg::*;
#(
    parameter int NUM_HOLES = DEFAULT_NUM_HOLES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inGame,
    input  logic                 round_start,
    input  logic [3:0]           position,
    input  logic [NUM_HOLES-1:0] btn,
    output logic [3:0]           mole_pos,
    output logic                 mole_active,
    output logic                 hit_pulse,
    output logic                 miss_pulse,
    output logic [BCD_W-1:0]     hit_ones,
    output logic [BCD_W-1:0]     hit_tens,
    output logic [BCD_W-1:0]     miss_ones,
    output logic [BCD_W-1:0]     miss_tens
);

    localparam logic [4:0] HOLES_W = 5'(NUM_HOLES);

    // inGame: two-flop synchronizer plus previous-value register for edge detect
    logic game_meta_reg;
    logic game_sync_reg;
    logic game_prev_reg;
    logic game_rise;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            game_meta_reg <= 1'b0;
            game_sync_reg <= 1'b0;
            game_prev_reg <= 1'b0;
        end else begin
            game_meta_reg <= inGame;
            game_sync_reg <= game_meta_reg;
            game_prev_reg <= game_sync_reg;
        end
    end

    assign game_rise = game_sync_reg & ~game_prev_reg;

    // Buttons: same structure per bit, yielding a one-cycle press pulse
    logic [NUM_HOLES-1:0] press;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_HOLES; gi++) begin : g_btn_sync
            logic meta_reg;
            logic sync_reg;
            logic prev_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                    prev_reg <= 1'b0;
                end else begin
                    meta_reg <= btn[gi];
                    sync_reg <= meta_reg;
                    prev_reg <= sync_reg;
                end
            end

            assign press[gi] = sync_reg & ~prev_reg;
        end
    endgenerate

    state_t               state_reg;
    logic [3:0]           mole_pos_reg;
    logic                 mole_active_reg;
    logic                 hit_pulse_reg;
    logic                 miss_pulse_reg;

    logic [NUM_HOLES-1:0] target;
    logic                 any_press;
    logic                 pos_valid;
    logic                 hit_now;
    logic                 miss_now;
    logic                 clr_now;

    assign target    = NUM_HOLES'(1) << mole_pos_reg;
    assign any_press = |press;
    assign pos_valid = {1'b0, position} < HOLES_W;

    // Judgement is combinational so the counters and the pulse registers
    // update on the same edge. A press always wins over a timeout: when a
    // press and round_start coincide, the press is judged against the old
    // mole and no timeout miss is counted.
    always_comb begin
        hit_now  = 1'b0;
        miss_now = 1'b0;
        clr_now  = 1'b0;
        if (game_sync_reg) begin
            case (state_reg)
                ST_IDLE: clr_now = game_rise;
                ST_ARMED: begin
                    if (any_press) begin
                        hit_now  = (press == target);
                        miss_now = (press != target);
                    end else begin
                        miss_now = round_start;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= ST_IDLE;
            mole_pos_reg    <= 4'd0;
            mole_active_reg <= 1'b0;
            hit_pulse_reg   <= 1'b0;
            miss_pulse_reg  <= 1'b0;
        end else begin
            hit_pulse_reg  <= hit_now;
            miss_pulse_reg <= miss_now;
            if (!game_sync_reg) begin
                state_reg       <= ST_IDLE;
                mole_active_reg <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (game_rise) begin
                            state_reg <= ST_WAIT_ROUND;
                        end
                    end
                    default: begin
                        // WAIT_ROUND, ARMED and RESOLVED all take a new round
                        // the same way; an out-of-range position voids it.
                        if (round_start) begin
                            if (pos_valid) begin
                                mole_pos_reg    <= position;
                                state_reg       <= ST_ARMED;
                                mole_active_reg <= 1'b1;
                            end else begin
                                state_reg       <= ST_WAIT_ROUND;
                                mole_active_reg <= 1'b0;
                            end
                        end else if (state_reg == ST_ARMED && any_press) begin
                            state_reg       <= ST_RESOLVED;
                            mole_active_reg <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    assign mole_pos    = mole_pos_reg;
    assign mole_active = mole_active_reg;
    assign hit_pulse   = hit_pulse_reg;
    assign miss_pulse  = miss_pulse_reg;

    bcd_counter_sat u_hit_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr_now),
        .inc  (hit_now),
        .ones (hit_ones),
        .tens (hit_tens)
    );

    bcd_counter_sat u_miss_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr_now),
        .inc  (miss_now),
        .ones (miss_ones),
        .tens (miss_tens)
    );

endmodule

// File: tb/tb_hit_judge.sv
// Self-checking bench for hit_judge: reset, a table of directed rounds,
// hand-written multi-cycle corner cases, and a random phase compared
// against a behavioural score-keeping model.
module tb_hit_judge;

    logic        clk = 1'b0;
    logic        rst;
    logic        inGame;
    logic        round_start;
    logic [3:0]  position;
    logic [15:0] btn;

    logic [3:0] mole_pos, mole_pos9;
    logic       mole_active, mole_active9;
    logic       hit_pulse, hit_pulse9, miss_pulse, miss_pulse9;
    logic [3:0] hit_ones, hit_tens, miss_ones, miss_tens;
    logic [3:0] hit_ones9, hit_tens9, miss_ones9, miss_tens9;

    int n_errors = 0;
    int n_checks = 0;

    always #10 clk = ~clk;

    hit_judge #(.NUM_HOLES(16)) dut (
        .clk(clk), .rst(rst), .inGame(inGame), .round_start(round_start),
        .position(position), .btn(btn), .mole_pos(mole_pos), .mole_active(mole_active),
        .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .hit_ones(hit_ones),
        .hit_tens(hit_tens), .miss_ones(miss_ones), .miss_tens(miss_tens)
    );

    hit_judge #(.NUM_HOLES(9)) dut9 (
        .clk(clk), .rst(rst), .inGame(inGame), .round_start(round_start),
        .position(position), .btn(btn[8:0]), .mole_pos(mole_pos9), .mole_active(mole_active9),
        .hit_pulse(hit_pulse9), .miss_pulse(miss_pulse9), .hit_ones(hit_ones9),
        .hit_tens(hit_tens9), .miss_ones(miss_ones9), .miss_tens(miss_tens9)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] bcd(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model (random phase) ----------------
    localparam int NH = 16;
    int          m_hits, m_misses, m_pos;
    int          m_phase;            // 0 off, 1 waiting, 2 mole up, 3 locked out
    bit          m_active, m_hp, m_mp;
    logic        ig_h[4];
    logic [15:0] b_h[4];

    task automatic model_reset();
        m_hits = 0; m_misses = 0; m_pos = 0; m_phase = 0;
        m_active = 0; m_hp = 0; m_mp = 0;
        for (int i = 0; i < 4; i++) begin
            ig_h[i] = 1'b0;
            b_h[i]  = 16'h0;
        end
    endtask

    // One clock edge with the inputs present at that edge. Buttons and
    // inGame are seen two samples late; an edge is "now high, before low".
    task automatic model_edge(input logic ig, input logic rs, input logic [3:0] p, input logic [15:0] b);
        logic [15:0] pr;
        bit          lvl, rise;
        for (int i = 3; i > 0; i--) begin
            ig_h[i] = ig_h[i-1];
            b_h[i]  = b_h[i-1];
        end
        ig_h[0] = ig;
        b_h[0]  = b;
        lvl  = ig_h[2];
        rise = ig_h[2] && !ig_h[3];
        pr   = b_h[2] & ~b_h[3];
        m_hp = 0;
        m_mp = 0;
        if (!lvl) begin
            m_phase  = 0;
            m_active = 0;
        end else if (m_phase == 0) begin
            if (rise) begin
                m_hits = 0; m_misses = 0; m_phase = 1;
            end
        end else begin
            if (m_phase == 2) begin
                if (pr != 0) begin
                    if (pr == (16'd1 << m_pos)) begin
                        m_hp = 1; if (m_hits < 99) m_hits++;
                    end else begin
                        m_mp = 1; if (m_misses < 99) m_misses++;
                    end
                    m_phase = 3;
                end else if (rs) begin
                    m_mp = 1; if (m_misses < 99) m_misses++;
                end
            end
            if (rs) begin
                if (int'(p) < NH) begin
                    m_pos = int'(p); m_phase = 2;
                end else begin
                    m_phase = 1;
                end
            end
            m_active = (m_phase == 2);
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit          is_round;
        logic [3:0]  pos;
        logic [15:0] press;
        int          hits;
        int          misses;
        bit          hp;
        bit          mp;
        bit          active;
        logic [3:0]  mpos;
    } vec_t;

    vec_t vecs[11];

    initial begin
        logic        hp_s, mp_s;
        logic [3:0]  p;
        logic [15:0] rb;
        int          hits_seen;
        int          sel;

        vecs[0]  = '{1'b1, 4'd5,  16'h0000, 0, 0, 1'b0, 1'b0, 1'b1, 4'd5};   // arm at 5
        vecs[1]  = '{1'b0, 4'd0,  16'h0020, 1, 0, 1'b1, 1'b0, 1'b0, 4'd5};   // hit
        vecs[2]  = '{1'b0, 4'd0,  16'h0020, 1, 0, 1'b0, 1'b0, 1'b0, 4'd5};   // lockout
        vecs[3]  = '{1'b1, 4'd3,  16'h0000, 1, 0, 1'b0, 1'b0, 1'b1, 4'd3};
        vecs[4]  = '{1'b0, 4'd0,  16'h0080, 1, 1, 1'b0, 1'b1, 1'b0, 4'd3};   // wrong hole
        vecs[5]  = '{1'b1, 4'd3,  16'h0000, 1, 1, 1'b0, 1'b0, 1'b1, 4'd3};
        vecs[6]  = '{1'b0, 4'd0,  16'h0018, 1, 2, 1'b0, 1'b1, 1'b0, 4'd3};   // multiple
        vecs[7]  = '{1'b1, 4'd10, 16'h0000, 1, 2, 1'b0, 1'b0, 1'b1, 4'd10};
        vecs[8]  = '{1'b1, 4'd11, 16'h0000, 1, 3, 1'b0, 1'b1, 1'b1, 4'd11};  // timeout
        vecs[9]  = '{1'b0, 4'd0,  16'h0800, 2, 3, 1'b1, 1'b0, 1'b0, 4'd11};
        vecs[10] = '{1'b1, 4'd2,  16'h0000, 2, 3, 1'b0, 1'b0, 1'b1, 4'd2};

        rst = 1'b0; inGame = 1'b0; round_start = 1'b0; position = 4'd0; btn = 16'h0;
        model_reset();

        // reset state
        repeat (3) tick();
        check("reset_active", mole_active, 1'b0);
        check("reset_pulses", {hit_pulse, miss_pulse}, 2'b00);
        check("reset_pos", mole_pos, 4'd0);
        check("reset_scores", {hit_tens, hit_ones, miss_tens, miss_ones}, 16'h0000);

        rst = 1'b1;
        tick();
        inGame = 1'b1;
        repeat (4) tick();

        for (int i = 0; i < 11; i++) begin
            if (vecs[i].is_round) begin
                round_start = 1'b1; position = vecs[i].pos;
                tick();
                hp_s = hit_pulse; mp_s = miss_pulse;
                round_start = 1'b0;
            end else begin
                btn = vecs[i].press;
                repeat (3) tick();
                hp_s = hit_pulse; mp_s = miss_pulse;
                btn = 16'h0;
                repeat (3) tick();
            end
            check($sformatf("vec%0d_pulses", i), {hp_s, mp_s}, {vecs[i].hp, vecs[i].mp});
            check($sformatf("vec%0d_hits", i), {hit_tens, hit_ones}, bcd(vecs[i].hits));
            check($sformatf("vec%0d_misses", i), {miss_tens, miss_ones}, bcd(vecs[i].misses));
            check($sformatf("vec%0d_active", i), mole_active, vecs[i].active);
            check($sformatf("vec%0d_pos", i), mole_pos, vecs[i].mpos);
            $display("vec %0d: round=%0d press=%04h hits=%0d%0d misses=%0d%0d", i,
                     vecs[i].is_round, vecs[i].press, hit_tens, hit_ones, miss_tens, miss_ones);
        end

        // press on the old mole in the same cycle as a new round_start
        btn = 16'h0004;
        tick(); tick();
        round_start = 1'b1; position = 4'd9;
        tick();
        check("simul_pulses", {hit_pulse, miss_pulse}, 2'b10);
        check("simul_pos", mole_pos, 4'd9);
        check("simul_active", mole_active, 1'b1);
        check("simul_scores", {hit_tens, hit_ones, miss_tens, miss_ones}, {bcd(3), bcd(3)});
        round_start = 1'b0; btn = 16'h0;
        tick();
        check("simul_pulse_width", {hit_pulse, miss_pulse}, 2'b00);
        $display("simultaneous: hits=%0d%0d misses=%0d%0d pos=%0d", hit_tens, hit_ones, miss_tens, miss_ones, mole_pos);

        // game gating: inputs ignored while inGame is low
        inGame = 1'b0;
        repeat (4) tick();
        check("gate_active", mole_active, 1'b0);
        round_start = 1'b1; position = 4'd6;
        tick();
        round_start = 1'b0;
        btn = 16'h0040;
        repeat (3) tick();
        check("gate_pulses", {hit_pulse, miss_pulse}, 2'b00);
        btn = 16'h0;
        repeat (3) tick();
        check("gate_hold", {hit_tens, hit_ones, miss_tens, miss_ones}, {bcd(3), bcd(3)});
        check("gate_active2", mole_active, 1'b0);
        inGame = 1'b1;
        tick(); tick();
        check("rise_not_yet", {hit_tens, hit_ones}, bcd(3));
        tick();
        check("rise_cleared", {hit_tens, hit_ones, miss_tens, miss_ones}, 16'h0000);
        $display("gating: cleared to %0d%0d/%0d%0d", hit_tens, hit_ones, miss_tens, miss_ones);

        // saturation
        hits_seen = 0;
        for (int i = 1; i <= 101; i++) begin
            p = 4'(i % 16);
            round_start = 1'b1; position = p;
            tick();
            round_start = 1'b0;
            btn = 16'd1 << p;
            repeat (3) tick();
            if (hit_pulse) hits_seen++;
            if (i == 10) check("carry_10", {hit_tens, hit_ones}, 8'h10);
            if (i >= 100) begin
                check($sformatf("sat_pulse_%0d", i), hit_pulse, 1'b1);
                check($sformatf("sat_digits_%0d", i), {hit_tens, hit_ones}, 8'h99);
            end
            btn = 16'h0;
            tick(); tick();
        end
        check("sat_pulse_count", hits_seen, 101);
        check("sat_misses", {miss_tens, miss_ones}, 8'h00);
        $display("saturation: hits=%0d%0d pulses=%0d", hit_tens, hit_ones, hits_seen);

        // void rounds on the 9-hole instance
        inGame = 1'b0; repeat (4) tick();
        inGame = 1'b1; repeat (4) tick();
        round_start = 1'b1; position = 4'd12; tick(); round_start = 1'b0;
        check("void_active9", mole_active9, 1'b0);
        check("void_active16", {mole_active, mole_pos}, {1'b1, 4'd12});
        tick();
        round_start = 1'b1; position = 4'd4; tick(); round_start = 1'b0;
        check("void_arm9", {mole_active9, mole_pos9, miss_pulse9}, {1'b1, 4'd4, 1'b0});
        check("void_timeout16", miss_pulse, 1'b1);
        btn = 16'h0010; repeat (3) tick();
        check("void_hit9", hit_pulse9, 1'b1);
        btn = 16'h0; repeat (3) tick();
        round_start = 1'b1; position = 4'd12; tick(); round_start = 1'b0;
        check("void_from_resolved9", {mole_active9, miss_pulse9}, 2'b00);
        tick();
        round_start = 1'b1; position = 4'd13; tick(); round_start = 1'b0;
        check("void_wait_nomiss9", {mole_active9, miss_pulse9}, 2'b00);
        tick();
        round_start = 1'b1; position = 4'd5; tick(); round_start = 1'b0;
        tick();
        round_start = 1'b1; position = 4'd14; tick(); round_start = 1'b0;
        check("void_armed_timeout9", {mole_active9, miss_pulse9}, 2'b01);
        check("void_scores9", {hit_tens9, hit_ones9, miss_tens9, miss_ones9}, {bcd(1), bcd(1)});
        $display("void rounds: dut9 hits=%0d%0d misses=%0d%0d", hit_tens9, hit_ones9, miss_tens9, miss_ones9);

        // asynchronous reset mid-round
        round_start = 1'b1; position = 4'd7; tick(); round_start = 1'b0;
        #5 rst = 1'b0;
        #1;
        check("areset_active", mole_active, 1'b0);
        check("areset_pos", mole_pos, 4'd0);
        check("areset_scores", {hit_tens, hit_ones, miss_tens, miss_ones}, 16'h0000);
        check("areset_scores9", {hit_tens9, hit_ones9, miss_tens9, miss_ones9}, 16'h0000);
        tick(); tick();
        rst = 1'b1;
        model_reset();
        $display("async reset: scores cleared");

        // random phase against the model
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 199) == 0) inGame = ~inGame;
            round_start = ($urandom_range(0, 9) == 0);
            position = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) begin
                sel = $urandom_range(0, 19);
                if (sel < 10)      rb = 16'h0;
                else if (sel < 15) rb = 16'd1 << m_pos;
                else if (sel < 18) rb = 16'd1 << $urandom_range(0, 15);
                else               rb = 16'($urandom);
                btn = rb;
            end
            @(posedge clk);
            model_edge(inGame, round_start, position, btn);
            #1;
            check($sformatf("rand_c%0d", c),
                  {mole_pos, mole_active, hit_pulse, miss_pulse, hit_tens, hit_ones, miss_tens, miss_ones},
                  {4'(m_pos), m_active, m_hp, m_mp, bcd(m_hits), bcd(m_misses)});
        end
        $display("random: final hits=%0d misses=%0d", m_hits, m_misses);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
